my_module: RTL and testbench

MY_MODULE -- requirements
Module: my_module

---
 rtl/my_module_pkg.sv | 21 ++
 rtl/my_module_if.sv | 10 +
 rtl/my_module.sv | 78 +++++++
 tb/tb_my_module.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/my_module_pkg.sv
// Shared types and frame constants for the my_module ID beacon.
// The frame layout is fixed here so every instance agrees on bit order.
package my_module_pkg;

  localparam int ID_W      = 8;
  localparam int VER_W     = 4;
  localparam int FRAME_LEN = 14;
  localparam int CNT_W     = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  // Frame layout, MSB sent first: start bit, ID, version, then even parity over ID and version.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [ID_W-1:0]  id,
                                                       input logic [VER_W-1:0] ver);
    return {1'b1, id, ver, ^{id, ver}};
  endfunction

endpackage

// File: rtl/my_module_if.sv
// Operand/result bundle for my_module.
// The testbench drives x and y; the block returns z.
interface my_module_if;
  logic x;
  logic y;
  logic z;

  modport master (output x, output y, input z);
  modport slave  (input x, input y, output z);
endinterface

// File: rtl/my_module.sv
// AND gate that turns into a 14-bit serial ID beacon when a rising y arrives with x high.
// The frame contents are fixed at elaboration from ID_NUM and VERSION.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | z follows x AND y one edge later; watch for the trigger
// ST_FRAME | shift out frame bits 1..13; inputs and triggers are ignored
module my_module
  import my_module_pkg::*;
#(
  parameter int ID_NUM  = 1,
  parameter int VERSION = 1
) (
  input logic       clk,
  input logic       rst,
  my_module_if.slave bus
);

  if (ID_NUM < 0 || ID_NUM > 255) begin : g_bad_id
    $error("my_module: ID_NUM must be in 0..255");
  end
  if (VERSION < 0 || VERSION > 15) begin : g_bad_ver
    $error("my_module: VERSION must be in 0..15");
  end

  localparam logic [ID_W-1:0]      ID_BITS    = ID_NUM[ID_W-1:0];
  localparam logic [VER_W-1:0]     VER_BITS   = VERSION[VER_W-1:0];
  localparam logic [FRAME_LEN-1:0] FRAME_BITS = build_frame(ID_BITS, VER_BITS);
  localparam logic [CNT_W-1:0]     LAST_CNT   = CNT_W'(FRAME_LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] bit_idx;
  logic             y_q;
  logic             trig;

  // y_q resets high so a y already asserted at reset release is not seen as a rising edge.
  assign trig    = bus.x & bus.y & ~y_q;
  assign bit_idx = LAST_CNT - cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      y_q   <= 1'b1;
      bus.z <= 1'b0;
    end else begin
      y_q <= bus.y;
      case (state)
        ST_IDLE: begin
          if (trig) begin
            state <= ST_FRAME;
            cnt   <= CNT_W'(1);
            bus.z <= FRAME_BITS[FRAME_LEN-1];
          end else begin
            bus.z <= bus.x & bus.y;
          end
        end
        ST_FRAME: begin
          bus.z <= FRAME_BITS[bit_idx];
          // Parity goes out on this edge; the next edge already runs IDLE logic.
          if (cnt == LAST_CNT) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          bus.z <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_my_module.sv
// Directed bench for my_module: three instances (ID 1, 99, 2) share stimulus,
// expected z values go through per-instance scoreboard queues.
module tb_my_module;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  my_module_if b0();
  my_module_if b1();
  my_module_if b2();

  my_module #(.ID_NUM(1),  .VERSION(1)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  my_module #(.ID_NUM(99), .VERSION(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  my_module #(.ID_NUM(2),  .VERSION(1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int total = 0;
  int bad   = 0;

  logic [13:0] frames [3];
  int          fpos   [3];
  logic        yq_m;
  logic        exp_q  [3][$];

  function automatic logic z_of(input int i);
    case (i)
      0:       return b0.z;
      1:       return b1.z;
      default: return b2.z;
    endcase
  endfunction

  task automatic chk(input string tag, input int i, input logic obs, input logic expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s dut%0d observed=%b expected=%b", tag, i, obs, expv);
    end
  endtask

  task automatic drive(input logic xv, input logic yv);
    b0.x = xv; b0.y = yv;
    b1.x = xv; b1.y = yv;
    b2.x = xv; b2.y = yv;
  endtask

  // Reference: a frame is a list of 14 bits; once started it ignores inputs until exhausted.
  task automatic step(input string tag, input logic xv, input logic yv);
    logic e;
    drive(xv, yv);
    for (int i = 0; i < 3; i++) begin
      if (fpos[i] > 0) begin
        e = frames[i][13 - fpos[i]];
        fpos[i] = (fpos[i] == 13) ? 0 : fpos[i] + 1;
      end else if (xv && yv && !yq_m) begin
        e = frames[i][13];
        fpos[i] = 1;
      end else begin
        e = xv & yv;
      end
      exp_q[i].push_back(e);
    end
    yq_m = yv;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (exp_q[i].size() == 0) begin
        chk({tag, "_empty"}, i, 1'b1, 1'b0);
      end else begin
        chk(tag, i, z_of(i), exp_q[i].pop_front());
      end
    end
  endtask

  task automatic reset_now(input string tag);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk(tag, i, z_of(i), 1'b0);
      fpos[i] = 0;
      exp_q[i].delete();
    end
    yq_m = 1'b1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    frames[0] = 14'b1_00000001_0001_0;
    frames[1] = 14'b1_01100011_0001_1;
    frames[2] = 14'b1_00000010_0001_0;
    for (int i = 0; i < 3; i++) fpos[i] = 0;
    yq_m = 1'b1;
    rst  = 1'b0;
    drive(1'b0, 1'b0);

    // Reset with no clock edge, y held high through release
    #2;
    reset_now("rst_async");
    drive(1'b1, 1'b1);
    release_rst();
    step("rst_hold_y", 1'b1, 1'b1);
    step("rst_hold_y", 1'b1, 1'b1);
    step("rst_hold_y", 1'b1, 1'b1);

    // Gate: y rises with x low, then x rises with y already high
    step("gate", 1'b0, 1'b0);
    step("gate", 1'b0, 1'b1);
    step("gate", 1'b0, 1'b1);
    step("gate", 1'b1, 1'b1);
    step("gate", 1'b1, 1'b1);
    step("gate", 1'b1, 1'b0);
    step("gate", 1'b0, 1'b0);

    // Plain frame followed by gating
    step("frame", 1'b1, 1'b0);
    step("frame", 1'b1, 1'b1);
    for (int k = 0; k < 13; k++) step("frame", 1'b1, 1'b1);
    step("frame_end", 1'b1, 1'b1);
    step("frame_end", 1'b0, 1'b1);
    step("frame_end", 1'b0, 1'b0);

    // y toggling during a frame; trigger exactly on the return edge
    step("retrig", 1'b1, 1'b0);
    step("retrig", 1'b1, 1'b1);
    for (int k = 1; k <= 13; k++) step("retrig", 1'b1, (k % 2 == 0));
    step("retrig_edge", 1'b1, 1'b1);
    for (int k = 0; k < 13; k++) step("retrig2", 1'b0, 1'b1);
    step("retrig_end", 1'b1, 1'b1);
    step("retrig_end", 1'b0, 1'b0);

    // Async reset while z is high in IDLE
    step("gate_hi", 1'b1, 1'b1);
    reset_now("rst_mid");
    release_rst();
    step("rst_mid_after", 1'b1, 1'b1);

    // Abort during the 5th ID bit, then a full frame
    step("abort", 1'b1, 1'b0);
    step("abort", 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) step("abort", 1'b1, 1'b0);
    reset_now("abort_rst");
    drive(1'b0, 1'b0);
    release_rst();
    step("abort_gate", 1'b1, 1'b1);
    step("abort_gate", 1'b0, 1'b1);
    step("abort_gate", 1'b1, 1'b0);
    step("abort_frame", 1'b1, 1'b1);
    for (int k = 0; k < 13; k++) step("abort_frame", 1'b0, 1'b0);
    step("abort_end", 1'b1, 1'b1);
    step("abort_end", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
